// File: rtl/mem_access_ctrl.sv
// Word-addressed RAM behind the MAR/MDR pair. It runs one read or write per
// request, stalls for WAIT_STATES cycles, and then reports completion with
// a one-cycle done pulse. The array has no reset; everything else clears
// synchronously.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_req,
    input  logic                  write_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned Depth    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    is_write_q;
    logic                    error_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic [DATA_WIDTH-1:0]   mem [Depth];

    logic accept;
    logic reject;
    logic access;

    // Request decode. Requests outside IDLE are dropped rather than queued.
    always_comb begin
        accept = (state_q == StIdle) && (read_req ^ write_req);
        reject = (state_q == StIdle) && read_req && write_req;
        access = (state_q == StWait) && (cnt_q == 4'd0);
    end

    // Next-state logic for the access sequencer and its wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = WaitInit;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control state, request latches, error pulse and read-data register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            error_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= reject;
            if (accept) begin
                addr_q     <= address;
                wdata_q    <= data_in;
                is_write_q <= write_req;
            end
            if (access && !is_write_q) begin
                data_out_q <= mem[addr_q];
            end
        end
    end

    // Array write port; clear on the access edge discards the pending write.
    always_ff @(posedge clock) begin
        if (!clear && access && is_write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy     = (state_q == StWait);
        done     = (state_q == StDone);
        error    = error_q;
        data_out = data_out_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one instance with two wait states, one with none.
// Stimulus pushes the expected completion (cycle, data_out, busy length) into
// a queue; a negedge monitor pops and compares whenever done or error shows.
module tb_mem_access_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        int          busy_len;
    } exp_t;

    logic        clock;
    logic        clear_a, clear_b;
    logic [8:0]  address_a, address_b;
    logic [31:0] data_in_a, data_in_b;
    logic        read_req_a, read_req_b, write_req_a, write_req_b;
    logic [31:0] data_out_a, data_out_b;
    logic        busy_a, busy_b, done_a, done_b, error_a, error_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   run [2];
    exp_t qa [$];
    exp_t qb [$];
    int   erra [$];
    int   errb [$];

    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(2)) dut_a (
        .clock(clock), .clear(clear_a), .address(address_a), .data_in(data_in_a),
        .read_req(read_req_a), .write_req(write_req_a), .data_out(data_out_a),
        .busy(busy_a), .done(done_a), .error(error_a)
    );

    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(0)) dut_b (
        .clock(clock), .clear(clear_b), .address(address_b), .data_in(data_in_b),
        .read_req(read_req_b), .write_req(write_req_b), .data_out(data_out_b),
        .busy(busy_b), .done(done_b), .error(error_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic dn, input logic bs, input logic er,
                       input logic [31:0] dout);
        exp_t e;
        int   ec;
        bit   empty;
        if (dn) begin
            empty = (id == 0) ? (qa.size() == 0) : (qb.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done dut%0d: got done=1 expected 0 (cycle %0d)",
                         id, cyc);
            end else begin
                if (id == 0) e = qa.pop_front();
                else         e = qb.pop_front();
                chk($sformatf("done_cycle dut%0d", id), 32'(cyc), 32'(e.cyc));
                chk($sformatf("data_out dut%0d", id), dout, e.data);
                chk($sformatf("busy_len dut%0d", id), 32'(run[id]), 32'(e.busy_len));
            end
        end
        if (er) begin
            empty = (id == 0) ? (erra.size() == 0) : (errb.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_error dut%0d: got error=1 expected 0 (cycle %0d)",
                         id, cyc);
            end else begin
                if (id == 0) ec = erra.pop_front();
                else         ec = errb.pop_front();
                chk($sformatf("error_cycle dut%0d", id), 32'(cyc), 32'(ec));
                chk($sformatf("error_busy dut%0d", id), {31'd0, bs}, 32'd0);
            end
        end
        if (bs) run[id]++;
        else    run[id] = 0;
    endtask

    always @(negedge clock) begin
        mon(0, done_a, busy_a, error_a, data_out_a);
        mon(1, done_b, busy_b, error_b, data_out_b);
    end

    task automatic drive(input int id, input bit rd, input bit wr, input logic [8:0] a,
                         input logic [31:0] d);
        if (id == 0) begin
            read_req_a = rd; write_req_a = wr; address_a = a; data_in_a = d;
        end else begin
            read_req_b = rd; write_req_b = wr; address_b = a; data_in_b = d;
        end
    endtask

    // One request; address/data are scrambled after the request edge so the
    // latched copies must be used.
    task automatic issue(input int id, input bit rd, input bit wr, input logic [8:0] a,
                         input logic [31:0] d, input logic [31:0] exp_dout);
        int   k;
        int   w;
        exp_t e;
        w = (id == 0) ? 2 : 0;
        @(posedge clock); #1;
        drive(id, rd, wr, a, d);
        @(posedge clock); #1;
        k = cyc;
        drive(id, 1'b0, 1'b0, 9'h1AB, ~d);
        if (rd && wr) begin
            if (id == 0) erra.push_back(k);
            else         errb.push_back(k);
        end else begin
            e.cyc = k + w + 1; e.data = exp_dout; e.busy_len = w + 1;
            if (id == 0) qa.push_back(e);
            else         qb.push_back(e);
        end
        repeat (w + 2) @(posedge clock);
    endtask

    initial begin
        int   k;
        exp_t e;
        run[0] = 0;
        run[1] = 0;
        clear_a = 1'b1;
        clear_b = 1'b1;
        drive(0, 1'($urandom), 1'($urandom), 9'($urandom), $urandom);
        drive(1, 1'($urandom), 1'($urandom), 9'($urandom), $urandom);
        @(posedge clock); #1;
        drive(0, 1'($urandom), 1'($urandom), 9'($urandom), $urandom);
        drive(1, 1'($urandom), 1'($urandom), 9'($urandom), $urandom);
        @(posedge clock); #1;
        clear_a = 1'b0;
        clear_b = 1'b0;
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clock);
        chk("reset data_out a", data_out_a, 32'h0);
        chk("reset busy a", {31'd0, busy_a}, 32'd0);
        chk("reset done a", {31'd0, done_a}, 32'd0);
        chk("reset error a", {31'd0, error_a}, 32'd0);
        chk("reset data_out b", data_out_b, 32'h0);
        chk("reset busy b", {31'd0, busy_b}, 32'd0);

        // W = 2: write then read back.
        issue(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0);
        issue(0, 1'b1, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF);
        // Rejected double request must leave 0x010 intact.
        issue(0, 1'b0, 1'b1, 9'h010, 32'h0000AAAA, 32'hDEADBEEF);
        issue(0, 1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, 32'h0);
        issue(0, 1'b1, 1'b0, 9'h010, 32'h0, 32'h0000AAAA);

        // Clear in WAIT discards the write and zeroes data_out.
        issue(0, 1'b0, 1'b1, 9'h020, 32'h11111111, 32'h0000AAAA);
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b1, 9'h020, 32'hCAFEF00D);
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        clear_a = 1'b1;
        @(posedge clock); #1;
        clear_a = 1'b0;
        @(negedge clock);
        chk("clear busy", {31'd0, busy_a}, 32'd0);
        chk("clear data_out", data_out_a, 32'h0);
        repeat (4) @(posedge clock);
        issue(0, 1'b1, 1'b0, 9'h020, 32'h0, 32'h11111111);

        // Reads asserted during WAIT and DONE of a write are ignored.
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b1, 9'h030, 32'h33333333);
        @(posedge clock); #1;
        k = cyc;
        e.cyc = k + 3; e.data = 32'h11111111; e.busy_len = 3;
        qa.push_back(e);
        drive(0, 1'b1, 1'b0, 9'h031, 32'h0);
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b0, 9'h031, 32'h0);
        @(posedge clock);
        @(posedge clock); #1;
        drive(0, 1'b1, 1'b0, 9'h031, 32'h0);
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("ignored data_out", data_out_a, 32'h11111111);
        issue(0, 1'b1, 1'b0, 9'h030, 32'h0, 32'h33333333);

        // W = 0: preload, single read, then back-to-back held request.
        issue(1, 1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'h0);
        issue(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 32'h12345678);
        @(posedge clock); #1;
        drive(1, 1'b1, 1'b0, 9'h1FF, 32'h0);
        @(posedge clock); #1;
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            e.cyc = k + 1 + 3 * i; e.data = 32'h12345678; e.busy_len = 1;
            qb.push_back(e);
        end
        repeat (8) @(posedge clock);
        #1;
        drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
        repeat (4) @(posedge clock);
        @(negedge clock);

        chk("pending done a", 32'(qa.size()), 32'd0);
        chk("pending done b", 32'(qb.size()), 32'd0);
        chk("pending error a", 32'(erra.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
